// File: rtl/lsb_queue.sv
// lsb_queue: multi-entry in-order load/store buffer between the ROB and the
// memory controller. Ops are issued strictly from the head of a circular
// queue; loads issue as soon as they reach the head, while stores wait for
// the ROB commit. Committed stores are retained across a flush.
module lsb_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 6,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_valid,
    input  logic [ROB_W-1:0] in_rob_index,
    input  logic [5:0]       in_opcode,
    input  logic             in_is_store,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_sdata,
    output logic             full,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob_index,
    input  logic             flush,
    output logic             mem_valid,
    output logic             mem_ls,
    output logic [5:0]       mem_opcode,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_sdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_ldata,
    output logic             res_valid,
    output logic [ROB_W-1:0] res_rob_index,
    output logic [31:0]      res_data
);

    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             vld;
        logic             cmt;
        logic             st;
        logic [ROB_W-1:0] rob;
        logic [5:0]       op;
        logic [31:0]      addr;
        logic [31:0]      sdata;
    } entry_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    entry_t             r_q [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_ccnt;
    state_t             r_state;

    logic               r_mem_valid;
    logic               r_mem_ls;
    logic [5:0]         r_mem_opcode;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_sdata;
    logic [ROB_W-1:0]   r_mem_rob;
    logic               r_res_valid;
    logic [ROB_W-1:0]   r_res_rob;
    logic [31:0]        r_res_data;

    logic               w_full;
    logic               w_enq;
    logic               w_pop;
    logic [DEPTH-1:0]   w_cmt_hit;
    logic               w_cmt_any;
    logic               w_head_ok;
    logic               w_issue;
    logic [PTR_W-1:0]   w_head_nxt;
    logic [CNT_W-1:0]   w_ccnt_nxt;
    entry_t             w_hd;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_hd   = r_q[r_head];

    // Enqueue is blocked by flush; full is evaluated before any pop.
    assign w_enq = rdy && in_valid && !w_full && !flush;

    // A flush aborts an in-flight load, so its completion never pops.
    assign w_pop = rdy && (r_state == S_BUSY) && mem_done && !(flush && r_mem_ls);

    // Head may issue if it is a load or an already-committed store.
    assign w_head_ok = w_hd.vld && (!w_hd.st || w_hd.cmt);
    assign w_issue   = rdy && (r_state == S_IDLE) && !flush && w_head_ok;

    // Commit tag match against every valid store entry.
    always_comb begin
        w_cmt_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cmt_hit[i] = rdy && commit_valid && r_q[i].vld && r_q[i].st &&
                           (r_q[i].rob == commit_rob_index);
        end
    end
    assign w_cmt_any = |w_cmt_hit;

    assign w_head_nxt = r_head + PTR_W'(w_pop);
    assign w_ccnt_nxt = r_ccnt + CNT_W'(w_cmt_any) - CNT_W'(w_pop && !r_mem_ls);

    // Queue storage, pointers, occupancy and committed-store count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ccnt  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cmt_hit[i]) r_q[i].cmt <= 1'b1;
                // Committed stores form a prefix from head; everything else dies.
                if (flush && !(r_q[i].cmt || w_cmt_hit[i])) begin
                    r_q[i].vld <= 1'b0;
                    r_q[i].cmt <= 1'b0;
                end
            end
            if (w_pop) begin
                r_q[r_head].vld <= 1'b0;
                r_q[r_head].cmt <= 1'b0;
            end
            if (w_enq) begin
                r_q[r_tail] <= '{vld: 1'b1, cmt: 1'b0, st: in_is_store,
                                 rob: in_rob_index, op: in_opcode,
                                 addr: in_addr, sdata: in_sdata};
            end
            r_head <= w_head_nxt;
            r_ccnt <= w_ccnt_nxt;
            if (flush) begin
                r_tail  <= w_head_nxt + w_ccnt_nxt[PTR_W-1:0];
                r_count <= w_ccnt_nxt;
            end else begin
                if (w_enq) r_tail <= r_tail + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
            end
        end
    end

    // Issue FSM with registered memory-request and load-result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_valid  <= 1'b0;
            r_mem_ls     <= 1'b0;
            r_mem_opcode <= '0;
            r_mem_addr   <= '0;
            r_mem_sdata  <= '0;
            r_mem_rob    <= '0;
            r_res_valid  <= 1'b0;
            r_res_rob    <= '0;
            r_res_data   <= '0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    r_res_valid <= 1'b0;
                    if (w_issue) begin
                        r_mem_valid  <= 1'b1;
                        r_mem_ls     <= !w_hd.st;
                        r_mem_opcode <= w_hd.op;
                        r_mem_addr   <= w_hd.addr;
                        r_mem_sdata  <= w_hd.sdata;
                        r_mem_rob    <= w_hd.rob;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush && r_mem_ls) begin
                        // Memory aborts the load; any late done is ignored in IDLE.
                        r_mem_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (mem_done) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_res_valid <= r_mem_ls;
                        if (r_mem_ls) begin
                            r_res_rob  <= r_mem_rob;
                            r_res_data <= mem_ldata;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (flush) r_res_valid <= 1'b0;
        end
    end

    assign full          = w_full;
    assign mem_valid     = r_mem_valid;
    assign mem_ls        = r_mem_ls;
    assign mem_opcode    = r_mem_opcode;
    assign mem_addr      = r_mem_addr;
    assign mem_sdata     = r_mem_sdata;
    assign res_valid     = r_res_valid;
    assign res_rob_index = r_res_rob;
    assign res_data      = r_res_data;

endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed scenarios plus randomized traffic for lsb_queue,
// checked every cycle against a queue-based reference model.
module tb_lsb_queue;

    localparam int DEPTH = 8;
    localparam int ROB_W = 6;

    logic             clk = 1'b0;
    logic             rst, rdy, in_valid, in_is_store, commit_valid, flush, mem_done;
    logic [ROB_W-1:0] in_rob_index, commit_rob_index;
    logic [5:0]       in_opcode;
    logic [31:0]      in_addr, in_sdata, mem_ldata;
    logic             full, mem_valid, mem_ls, res_valid;
    logic [5:0]       mem_opcode;
    logic [31:0]      mem_addr, mem_sdata, res_data;
    logic [ROB_W-1:0] res_rob_index;

    int n_vec = 0;
    int n_err = 0;

    lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_rob_index(in_rob_index), .in_opcode(in_opcode),
        .in_is_store(in_is_store), .in_addr(in_addr), .in_sdata(in_sdata),
        .full(full),
        .commit_valid(commit_valid), .commit_rob_index(commit_rob_index),
        .flush(flush),
        .mem_valid(mem_valid), .mem_ls(mem_ls), .mem_opcode(mem_opcode),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .mem_done(mem_done), .mem_ldata(mem_ldata),
        .res_valid(res_valid), .res_rob_index(res_rob_index), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Reference model: program-order list of buffered ops plus the in-flight request.
    typedef struct {
        logic [ROB_W-1:0] tag;
        bit               st;
        logic [5:0]       op;
        logic [31:0]      addr;
        logic [31:0]      sdata;
        bit               cmt;
    } ent_t;

    ent_t             q[$];
    bit               m_mv, m_ls, m_rv;
    logic [5:0]       m_op;
    logic [31:0]      m_addr, m_sd, m_rdata;
    logic [ROB_W-1:0] m_tag, m_rtag;
    logic [ROB_W-1:0] nxt_tag = 6'd20;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_upd();
        bit   elig, full_pre, pop;
        ent_t hd;
        ent_t kept[$];
        if (rst) begin
            q.delete();
            m_mv = 0; m_rv = 0; m_ls = 0;
            return;
        end
        if (!rdy) return;
        full_pre = (q.size() == DEPTH);
        elig = 0;
        if (q.size() > 0) begin
            hd   = q[0];
            elig = !hd.st || hd.cmt;
        end
        pop = m_mv && mem_done && !(flush && m_ls);
        if (commit_valid)
            foreach (q[i]) if (q[i].st && q[i].tag == commit_rob_index) q[i].cmt = 1;
        if (pop) void'(q.pop_front());
        if (flush) begin
            foreach (q[i]) if (q[i].cmt) kept.push_back(q[i]);
            q = kept;
        end
        if (in_valid && !full_pre && !flush)
            q.push_back('{in_rob_index, in_is_store, in_opcode, in_addr, in_sdata, 1'b0});
        if (!m_mv) begin
            m_rv = 0;
            if (elig && !flush) begin
                m_mv = 1; m_ls = !hd.st; m_op = hd.op;
                m_addr = hd.addr; m_sd = hd.sdata; m_tag = hd.tag;
            end
        end else if (flush && m_ls) begin
            m_mv = 0;
        end else if (mem_done) begin
            m_mv = 0;
            m_rv = m_ls;
            if (m_ls) begin
                m_rtag  = m_tag;
                m_rdata = mem_ldata;
            end
        end
        if (flush) m_rv = 0;
    endtask

    task automatic cmp();
        chk("full", full, (q.size() == DEPTH));
        chk("mem_valid", mem_valid, m_mv);
        if (m_mv) begin
            chk("mem_ls", mem_ls, m_ls);
            chk("mem_opcode", mem_opcode, m_op);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_sdata", mem_sdata, m_sd);
        end
        chk("res_valid", res_valid, m_rv);
        if (m_rv) begin
            chk("res_tag", res_rob_index, m_rtag);
            chk("res_data", res_data, m_rdata);
        end
    endtask

    // One clock: DUT and model advance together, outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        mdl_upd();
        @(negedge clk);
        cmp();
    endtask

    task automatic idle();
        rst = 0; rdy = 1; in_valid = 0; in_is_store = 0; in_rob_index = '0;
        in_opcode = '0; in_addr = '0; in_sdata = '0; commit_valid = 0;
        commit_rob_index = '0; flush = 0; mem_done = 0; mem_ldata = '0;
    endtask

    task automatic enq(input logic [ROB_W-1:0] t, input bit st,
                       input logic [31:0] a, input logic [31:0] d);
        in_valid = 1; in_rob_index = t; in_is_store = st;
        in_opcode = {st, 5'h02}; in_addr = a; in_sdata = d;
    endtask

    task automatic rnd_in();
        int fu;
        idle();
        rdy       = ($urandom_range(0, 7) != 0);
        flush     = ($urandom_range(0, 31) == 0);
        in_valid  = $urandom_range(0, 1);
        in_rob_index = nxt_tag;
        in_is_store  = $urandom_range(0, 1);
        in_opcode = 6'($urandom);
        in_addr   = $urandom;
        in_sdata  = $urandom;
        if (rdy && in_valid && !flush && q.size() < DEPTH) nxt_tag++;
        // Commit only the oldest uncommitted store, keeping commits in order.
        if ($urandom_range(0, 2) == 0) begin
            fu = -1;
            foreach (q[i]) if (fu < 0 && !q[i].cmt) fu = i;
            if (fu >= 0 && q[fu].st) begin
                commit_valid = 1; commit_rob_index = q[fu].tag;
            end else if (fu >= 0) begin
                commit_valid = 1; commit_rob_index = q[fu].tag;  // load tag: ignored
            end
        end
        mem_done  = m_mv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        mem_ldata = $urandom;
    endtask

    logic [ROB_W-1:0] got_tags[$];
    logic [ROB_W-1:0] exp_tags[$];

    initial begin
        idle();
        rst = 1;
        step();
        step();
        chk("rst_full", full, 0);
        chk("rst_mv", mem_valid, 0);
        chk("rst_ls", mem_ls, 0);
        chk("rst_op", mem_opcode, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_sd", mem_sdata, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_rtag", res_rob_index, 0);
        chk("rst_rdata", res_data, 0);
        idle();

        // Single load with a 4-cycle memory latency.
        enq(6'd3, 0, 32'h100, 32'h0);
        step(); idle();
        step();
        chk("t1_mv", mem_valid, 1);
        chk("t1_ls", mem_ls, 1);
        chk("t1_addr", mem_addr, 32'h100);
        repeat (3) step();
        mem_done = 1; mem_ldata = 32'hDEADBEEF;
        step(); idle();
        chk("t1_rv", res_valid, 1);
        chk("t1_rtag", res_rob_index, 3);
        chk("t1_rdata", res_data, 32'hDEADBEEF);
        step();
        chk("t1_rv_off", res_valid, 0);

        // Uncommitted store blocks until commit.
        enq(6'd5, 1, 32'h200, 32'h12345678);
        step(); idle();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_blocked", mem_valid, 0);
        end
        commit_valid = 1; commit_rob_index = 6'd5;
        step(); idle();
        step();
        chk("t2_mv", mem_valid, 1);
        chk("t2_ls", mem_ls, 0);
        chk("t2_sd", mem_sdata, 32'h12345678);
        mem_done = 1;
        step(); idle();
        chk("t2_no_res", res_valid, 0);
        step();

        // Fill, overflow drop, pop-then-refill, FIFO result order across wrap.
        for (int i = 0; i < DEPTH; i++) begin
            enq(6'(10 + i), 0, 32'(i * 4), 32'h0);
            step();
        end
        idle();
        chk("t3_full", full, 1);
        enq(6'd18, 0, 32'h900, 32'h0);
        step(); idle();
        chk("t3_drop", full, 1);
        mem_done = 1; mem_ldata = $urandom;
        step(); idle();
        chk("t3_pop", full, 0);
        if (res_valid) got_tags.push_back(res_rob_index);
        enq(6'd19, 0, 32'h904, 32'h0);
        step(); idle();
        chk("t3_refill", full, 1);
        for (int c = 0; c < 40; c++) begin
            mem_done = m_mv; mem_ldata = $urandom;
            step();
            if (res_valid) got_tags.push_back(res_rob_index);
        end
        idle();
        for (int i = 0; i < DEPTH; i++) exp_tags.push_back(6'(10 + i));
        exp_tags.push_back(6'd19);
        chk("t3_nres", got_tags.size(), exp_tags.size());
        foreach (exp_tags[i])
            if (i < got_tags.size()) chk("t3_order", got_tags[i], exp_tags[i]);

        // Flush while a committed store is in flight.
        enq(6'd1, 1, 32'h300, 32'hA);  step();
        enq(6'd2, 1, 32'h304, 32'hB);  step();
        enq(6'd3, 0, 32'h308, 32'h0);  step();
        idle(); commit_valid = 1; commit_rob_index = 6'd1;
        step(); idle();
        step();
        chk("t4_mv", mem_valid, 1);
        chk("t4_addr", mem_addr, 32'h300);
        flush = 1;
        step(); idle();
        chk("t4_keep", mem_valid, 1);
        repeat (2) step();
        mem_done = 1;
        step(); idle();
        chk("t4_done", mem_valid, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_no_issue", mem_valid, 0);
            chk("t4_no_res", res_valid, 0);
        end

        // Flush aborts an in-flight load; the late done is ignored.
        enq(6'd7, 0, 32'h400, 32'h0);
        step(); idle();
        step();
        chk("t5_mv", mem_valid, 1);
        flush = 1;
        step(); idle();
        chk("t5_drop", mem_valid, 0);
        mem_done = 1; mem_ldata = 32'h55AA55AA;
        step(); idle();
        chk("t5_no_res", res_valid, 0);
        step();
        chk("t5_no_res2", res_valid, 0);

        // rdy low freezes a busy op even with mem_done pulsing.
        enq(6'd9, 0, 32'h500, 32'h0);
        step(); idle();
        step();
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            mem_done = ~mem_done;
            step();
            chk("t6_hold_mv", mem_valid, 1);
            chk("t6_hold_rv", res_valid, 0);
        end
        idle();
        step();
        chk("t6_still", mem_valid, 1);
        mem_done = 1; mem_ldata = 32'hCAFEF00D;
        step(); idle();
        chk("t6_rv", res_valid, 1);
        chk("t6_rdata", res_data, 32'hCAFEF00D);
        step();

        // Randomized traffic with occasional mid-operation reset.
        for (int c = 0; c < 4000; c++) begin
            rnd_in();
            if (c % 700 == 699) begin
                rst = 1; rdy = 1;
            end
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
